// File: rtl/axi_rd_path_pkg.sv
// axi_rd_path_pkg: constants and helpers shared by the AXI4-to-SDRAM read
// and write paths.
//   BURST_INCR    - the only AXI burst type the SDRAM bridge supports
//   AXI_RESP_OKAY - response code returned on every R beat
//   CHUNK_BEATS   - words per memory fetch command (one BL8 access)
//   rd_state_e    - one-hot request FSM states of the read path
//   eff_len       - AXI length rounded up to whole chunks
package axi_rd_path_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         CHUNK_BEATS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_ISSUE = 2'b10
    } rd_state_e;

    // Round arlen up so the burst covers a whole number of 4-beat chunks.
    function automatic logic [7:0] eff_len(input logic [7:0] arlen);
        return {arlen[7:2], 2'b11};
    endfunction

endpackage

// File: rtl/axi_rd_path_checker.sv
// axi_rd_path_checker: simulation-time protocol checks for axi_rd_path.
// Reports unsupported AR requests and chunk framing errors from memory;
// the datapath itself carries on regardless.
// Ports: clock/reset, the AR request fields and the returned-data handshake.
module axi_rd_path_checker
    import axi_rd_path_pkg::*;
#(
    parameter int ADDRS = 32
) (
    input logic             clock,
    input logic             reset,
    input logic             arvalid,
    input logic             arready,
    input logic [ADDRS-1:0] araddr,
    input logic [7:0]       arlen,
    input logic [1:0]       arburst,
    input logic             mem_valid,
    input logic             mem_ready,
    input logic             mem_last
);

    logic [1:0] mem_beat_r;
    logic       unused_addr_s;

    assign unused_addr_s = ^araddr[ADDRS-1:4];

    // Position of the next returned beat inside its 4-beat chunk.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_beat_r <= 2'd0;
        end else if (mem_valid && mem_ready) begin
            mem_beat_r <= mem_beat_r + 2'd1;
        end
    end

    // Request legality and chunk framing checks.
    always_ff @(posedge clock) begin
        if (!reset && arvalid && arready) begin
            assert (arburst == BURST_INCR)
                else $error("axi_rd_path: unsupported arburst %b", arburst);
            assert (arlen[1:0] == 2'b11)
                else $error("axi_rd_path: arlen %0d is not a whole chunk", arlen);
            assert (araddr[3:0] == 4'h0)
                else $error("axi_rd_path: araddr %h not chunk aligned", araddr);
        end
        if (!reset && mem_valid && mem_ready) begin
            assert (mem_last == (mem_beat_r == 2'd3))
                else $error("axi_rd_path: mem_last out of step with chunk beats");
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with valid/ready on
// both sides. A word written in cycle M is visible at the output in M+1.
// Ports:
//   clock, reset            - clock and synchronous active-high reset
//   in_valid/in_ready       - write handshake, in_ready low when full
//   in_data                 - write data
//   out_valid/out_ready     - read handshake, out_valid high when not empty
//   out_data                - head word (zero while empty)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_r != CW'(DEPTH));
    assign out_valid = (count_r != CW'(0));
    assign out_data  = out_valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Storage array; contents need no reset because count_r qualifies them.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_path.sv
// axi_rd_path: AXI4 read path of the AXI4-to-SDRAM bridge.
// Splits each AR request into 4-beat fetch commands, buffers returned data
// and replays it on the R channel with RID/RLAST in AR-acceptance order.
// Fetches only go out when the data buffer has room for a whole chunk.
// Ports:
//   clock, reset                   - clock, synchronous active-high reset
//   axi_ar*                        - AXI read address channel
//   axi_r*                         - AXI read data channel
//   mem_fetch_o/mem_accept_i, mem_rseq_o, mem_rdid_o, mem_addr_o
//                                  - fetch command to the memory controller
//   mem_valid_i/mem_ready_o, mem_last_i, mem_data_i
//                                  - returned read data
module axi_rd_path
    import axi_rd_path_pkg::*;
#(
    parameter int ADDRS           = 32,
    parameter int WIDTH           = 32,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int CTRL_FIFO_DEPTH = 16,
    parameter int DATA_FIFO_DEPTH = 512
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    input  logic [ADDRS-1:0]        axi_araddr_i,
    input  logic [AXI_ID_WIDTH-1:0] axi_arid_i,
    input  logic [7:0]              axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    output logic                    axi_rlast_o,
    output logic [1:0]              axi_rresp_o,
    output logic [AXI_ID_WIDTH-1:0] axi_rid_o,
    output logic [WIDTH-1:0]        axi_rdata_o,
    output logic                    mem_fetch_o,
    input  logic                    mem_accept_i,
    output logic                    mem_rseq_o,
    output logic [AXI_ID_WIDTH-1:0] mem_rdid_o,
    output logic [ADDRS-1:0]        mem_addr_o,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic                    mem_last_i,
    input  logic [WIDTH-1:0]        mem_data_i
);

    localparam int MASKS  = WIDTH / 8;
    localparam int CW     = $clog2(DATA_FIFO_DEPTH) + 1;
    localparam int CTRL_W = AXI_ID_WIDTH + 8;

    localparam logic [ADDRS-1:0] CHUNK_STEP   = ADDRS'(CHUNK_BEATS * MASKS);
    localparam logic [CW-1:0]    CREDIT_MAX   = CW'(DATA_FIFO_DEPTH);
    localparam logic [CW-1:0]    CREDIT_CHUNK = CW'(CHUNK_BEATS);

    rd_state_e                state_r;
    rd_state_e                state_s;
    logic                     live_r;
    logic [ADDRS-1:0]         addr_r;
    logic [AXI_ID_WIDTH-1:0]  id_r;
    logic [5:0]               remaining_r;
    logic                     seq_r;
    logic [CW-1:0]            credits_r;
    logic [7:0]               beat_r;

    logic                     ar_hs_s;
    logic                     fetch_hs_s;
    logic                     r_hs_s;
    logic                     rlast_hs_s;
    logic                     ctrl_in_ready_s;
    logic                     ctrl_out_valid_s;
    logic [CTRL_W-1:0]        ctrl_out_data_s;
    logic                     data_out_valid_s;
    logic                     unused_inputs_s;

    assign ar_hs_s    = axi_arvalid_i && axi_arready_o;
    assign fetch_hs_s = mem_fetch_o && mem_accept_i;
    assign r_hs_s     = axi_rvalid_o && axi_rready_i;
    assign rlast_hs_s = r_hs_s && axi_rlast_o;

    // live_r holds arready low for the first cycle out of reset.
    assign axi_arready_o = live_r && (state_r == ST_IDLE) && ctrl_in_ready_s;
    assign mem_fetch_o   = (state_r == ST_ISSUE) && (credits_r >= CREDIT_CHUNK);
    assign mem_rseq_o    = seq_r;
    assign mem_rdid_o    = id_r;
    assign mem_addr_o    = addr_r;

    assign axi_rvalid_o = data_out_valid_s && ctrl_out_valid_s;
    assign axi_rlast_o  = ctrl_out_valid_s && (beat_r == ctrl_out_data_s[7:0]);
    assign axi_rid_o    = ctrl_out_data_s[CTRL_W-1:8];
    assign axi_rresp_o  = AXI_RESP_OKAY;

    // Burst type and chunk framing are only observed by the protocol checker.
    assign unused_inputs_s = ^{axi_arburst_i, mem_last_i};

    // Request FSM next state: accept one AR, then issue its chunks.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (fetch_hs_s && (remaining_r == 6'd0)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request FSM state and the chunk walker of the burst being issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            live_r      <= 1'b0;
            addr_r      <= {ADDRS{1'b0}};
            id_r        <= {AXI_ID_WIDTH{1'b0}};
            remaining_r <= 6'd0;
            seq_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            live_r  <= 1'b1;
            if (ar_hs_s) begin
                addr_r      <= axi_araddr_i;
                id_r        <= axi_arid_i;
                remaining_r <= axi_arlen_i[7:2];
                seq_r       <= 1'b0;
            end else if (fetch_hs_s) begin
                addr_r      <= addr_r + CHUNK_STEP;
                remaining_r <= remaining_r - 6'd1;
                seq_r       <= 1'b1;
            end
        end
    end

    // Free data-buffer slots not yet promised to an outstanding fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            credits_r <= CREDIT_MAX;
        end else begin
            case ({fetch_hs_s, r_hs_s})
                2'b10:   credits_r <= credits_r - CREDIT_CHUNK;
                2'b01:   credits_r <= credits_r + CW'(1);
                2'b11:   credits_r <= credits_r - CREDIT_CHUNK + CW'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Beat index within the AXI burst at the head of the ID/length FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_r <= 8'd0;
        end else if (rlast_hs_s) begin
            beat_r <= 8'd0;
        end else if (r_hs_s) begin
            beat_r <= beat_r + 8'd1;
        end
    end

    sync_fifo #(
        .WIDTH (CTRL_W),
        .DEPTH (CTRL_FIFO_DEPTH)
    ) u_ctrl_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (ar_hs_s),
        .in_ready  (ctrl_in_ready_s),
        .in_data   ({axi_arid_i, eff_len(axi_arlen_i)}),
        .out_valid (ctrl_out_valid_s),
        .out_ready (rlast_hs_s),
        .out_data  (ctrl_out_data_s)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DATA_FIFO_DEPTH)
    ) u_data_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (mem_valid_i),
        .in_ready  (mem_ready_o),
        .in_data   (mem_data_i),
        .out_valid (data_out_valid_s),
        .out_ready (r_hs_s),
        .out_data  (axi_rdata_o)
    );

endmodule

// File: tb/tb_axi_rd_path.sv
// tb_axi_rd_path: randomized self-checking bench for axi_rd_path with a
// small data buffer (8 words) and two outstanding requests, so credit and
// outstanding limits are reachable. A background process drives all inputs
// on the falling edge and logs handshakes; test tasks compare the logs with
// beats predicted from the AR requests and a simple memory content function.
module tb_axi_rd_path;

    localparam int DFD = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        rseq;
        logic [3:0]  id;
    } fetch_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        axi_arvalid_i = 1'b0;
    logic        axi_arready_o;
    logic [31:0] axi_araddr_i = 32'h0;
    logic [3:0]  axi_arid_i = 4'h0;
    logic [7:0]  axi_arlen_i = 8'h0;
    logic [1:0]  axi_arburst_i = 2'b01;
    logic        axi_rvalid_o;
    logic        axi_rready_i = 1'b0;
    logic        axi_rlast_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;
    logic        mem_fetch_o;
    logic        mem_accept_i = 1'b0;
    logic        mem_rseq_o;
    logic [3:0]  mem_rdid_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic        mem_last_i = 1'b0;
    logic [31:0] mem_data_i = 32'h0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    ar_t         ar_q[$];
    fetch_t      fetch_q[$];
    logic [32:0] mem_q[$];

    int ar_count = 0;
    int fetch_count = 0;
    int ar_cyc = -1;
    int fetch_cyc = -1;
    int mem_first_cyc = -1;
    int rvalid_first_cyc = -1;
    int stab_err = 0;
    int ovf_err = 0;
    int rr_pct = 100;
    int acc_pct = 100;
    int mv_pct = 100;
    int rr_budget = -1;

    logic  hold_prev = 1'b0;
    beat_t prev_beat;

    always #5 clock = ~clock;

    axi_rd_path #(
        .ADDRS           (32),
        .WIDTH           (32),
        .AXI_ID_WIDTH    (4),
        .CTRL_FIFO_DEPTH (2),
        .DATA_FIFO_DEPTH (DFD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .axi_arvalid_i (axi_arvalid_i),
        .axi_arready_o (axi_arready_o),
        .axi_araddr_i  (axi_araddr_i),
        .axi_arid_i    (axi_arid_i),
        .axi_arlen_i   (axi_arlen_i),
        .axi_arburst_i (axi_arburst_i),
        .axi_rvalid_o  (axi_rvalid_o),
        .axi_rready_i  (axi_rready_i),
        .axi_rlast_o   (axi_rlast_o),
        .axi_rresp_o   (axi_rresp_o),
        .axi_rid_o     (axi_rid_o),
        .axi_rdata_o   (axi_rdata_o),
        .mem_fetch_o   (mem_fetch_o),
        .mem_accept_i  (mem_accept_i),
        .mem_rseq_o    (mem_rseq_o),
        .mem_rdid_o    (mem_rdid_o),
        .mem_addr_o    (mem_addr_o),
        .mem_valid_i   (mem_valid_i),
        .mem_ready_o   (mem_ready_o),
        .mem_last_i    (mem_last_i),
        .mem_data_i    (mem_data_i)
    );

    axi_rd_path_checker #(.ADDRS(32)) chk (
        .clock     (clock),
        .reset     (reset),
        .arvalid   (axi_arvalid_i),
        .arready   (axi_arready_o),
        .araddr    (axi_araddr_i),
        .arlen     (axi_arlen_i),
        .arburst   (axi_arburst_i),
        .mem_valid (mem_valid_i),
        .mem_ready (mem_ready_o),
        .mem_last  (mem_last_i)
    );

    // Memory content: a fixed scramble of the word's byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Queue an AR request and predict its R beats: L+1 consecutive words.
    task automatic push_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        ar_t   r;
        beat_t b;
        int    eff;
        r.addr = addr;
        r.id   = id;
        r.len  = len;
        ar_q.push_back(r);
        eff = (int'(len) / 4) * 4 + 3;
        for (int i = 0; i <= eff; i++) begin
            b.data = mem_word(addr + 32'(4 * i));
            b.id   = id;
            b.last = (i == eff);
            b.resp = 2'b00;
            exp_q.push_back(b);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_obs(input int n, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (obs_q.size() >= n) break;
            cycles(1);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        obs_q.delete();
        fetch_q.delete();
        ar_count = 0;
        fetch_count = 0;
        ar_cyc = -1;
        fetch_cyc = -1;
        mem_first_cyc = -1;
        rvalid_first_cyc = -1;
    endtask

    // Falling-edge driver and handshake logger (outputs settle #1 later).
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                axi_arvalid_i = 1'b0;
                mem_accept_i  = 1'b0;
                mem_valid_i   = 1'b0;
                mem_last_i    = 1'b0;
                axi_rready_i  = 1'b0;
                hold_prev     = 1'b0;
            end else begin
                if (ar_q.size() > 0) begin
                    axi_arvalid_i = 1'b1;
                    axi_araddr_i  = ar_q[0].addr;
                    axi_arid_i    = ar_q[0].id;
                    axi_arlen_i   = ar_q[0].len;
                end else begin
                    axi_arvalid_i = 1'b0;
                end
                mem_accept_i = ($urandom_range(99, 0) < acc_pct);
                if (mem_q.size() > 0 && $urandom_range(99, 0) < mv_pct) begin
                    mem_valid_i = 1'b1;
                    mem_data_i  = mem_word(mem_q[0][31:0]);
                    mem_last_i  = mem_q[0][32];
                end else begin
                    mem_valid_i = 1'b0;
                    mem_last_i  = 1'b0;
                end
                axi_rready_i = (rr_budget != 0) && ($urandom_range(99, 0) < rr_pct);
                #1;
                if (hold_prev && (!axi_rvalid_o ||
                    {axi_rdata_o, axi_rid_o, axi_rlast_o, axi_rresp_o} !== prev_beat)) begin
                    stab_err++;
                end
                hold_prev = axi_rvalid_o && !axi_rready_i;
                prev_beat = {axi_rdata_o, axi_rid_o, axi_rlast_o, axi_rresp_o};
                if (axi_arvalid_i && axi_arready_o) begin
                    void'(ar_q.pop_front());
                    ar_count++;
                    ar_cyc = cyc;
                end
                if (mem_fetch_o && mem_accept_i) begin
                    fetch_q.push_back({mem_addr_o, mem_rseq_o, mem_rdid_o});
                    for (int i = 0; i < 4; i++) begin
                        mem_q.push_back({(i == 3), mem_addr_o + 32'(4 * i)});
                    end
                    fetch_count++;
                    fetch_cyc = cyc;
                end
                if (mem_valid_i && !mem_ready_o) ovf_err++;
                if (mem_valid_i && mem_ready_o) begin
                    void'(mem_q.pop_front());
                    if (mem_first_cyc < 0) mem_first_cyc = cyc;
                end
                if (axi_rvalid_o && rvalid_first_cyc < 0) rvalid_first_cyc = cyc;
                if (axi_rvalid_o && axi_rready_i) begin
                    obs_q.push_back({axi_rdata_o, axi_rid_o, axi_rlast_o, axi_rresp_o});
                    if (rr_budget > 0) rr_budget--;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        cycles(3);
        checks++;
        if ({axi_arready_o, mem_fetch_o, axi_rvalid_o, axi_rlast_o, axi_rresp_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {axi_arready_o, mem_fetch_o, axi_rvalid_o, axi_rlast_o, axi_rresp_o});
        end
        reset = 1'b0;
        checks++;
        if (axi_arready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_arready_early got=%b want=0", axi_arready_o);
        end
        cycles(1);
        checks++;
        if (axi_arready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_arready_after got=%b want=1", axi_arready_o);
        end
        checks++;
        if (dut.credits_r !== 4'(DFD)) begin
            failures++;
            $display("FAIL reset_credits got=%0d want=%0d", dut.credits_r, DFD);
        end
    endtask

    task automatic test_single();
        fetch_t f;
        clear_logs();
        rr_pct = 100; acc_pct = 100; mv_pct = 100; rr_budget = -1;
        push_ar(32'h100, 4'd5, 8'd3);
        wait_obs(4, 60);
        checks++;
        if (fetch_q.size() != 1) begin
            failures++;
            $display("FAIL single_fetch_count got=%0d want=1", fetch_q.size());
        end else begin
            f = {32'h100, 1'b0, 4'd5};
            checks++;
            if (fetch_q[0] !== f) begin
                failures++;
                $display("FAIL single_fetch got=%h want=%h", fetch_q[0], f);
            end
        end
        checks++;
        if (fetch_cyc - ar_cyc != 1) begin
            failures++;
            $display("FAIL single_ar_to_fetch got=%0d want=1", fetch_cyc - ar_cyc);
        end
        checks++;
        if (rvalid_first_cyc - mem_first_cyc != 1) begin
            failures++;
            $display("FAIL single_mem_to_rvalid got=%0d want=1", rvalid_first_cyc - mem_first_cyc);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_beat[%0d] got=%h want=%h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_long();
        fetch_t f;
        clear_logs();
        push_ar(32'h200, 4'd9, 8'd15);
        wait_obs(16, 200);
        checks++;
        if (fetch_q.size() != 4) begin
            failures++;
            $display("FAIL long_fetch_count got=%0d want=4", fetch_q.size());
        end
        for (int i = 0; i < 4 && i < fetch_q.size(); i++) begin
            f = {32'h200 + 32'(16 * i), (i != 0), 4'd9};
            checks++;
            if (fetch_q[i] !== f) begin
                failures++;
                $display("FAIL long_fetch[%0d] got=%h want=%h", i, fetch_q[i], f);
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL long_beat[%0d] got=%h want=%h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_credit();
        clear_logs();
        rr_budget = 0;
        push_ar(32'h1000, 4'd3, 8'd15);
        cycles(30);
        checks++;
        if (fetch_count != 2 || mem_fetch_o !== 1'b0) begin
            failures++;
            $display("FAIL credit_stall got=%0d/%b want=2/0", fetch_count, mem_fetch_o);
        end
        rr_budget = 4;
        cycles(20);
        checks++;
        if (fetch_count != 3) begin
            failures++;
            $display("FAIL credit_release1 got=%0d want=3", fetch_count);
        end
        rr_budget = 4;
        cycles(20);
        checks++;
        if (fetch_count != 4) begin
            failures++;
            $display("FAIL credit_release2 got=%0d want=4", fetch_count);
        end
        rr_budget = -1;
        wait_obs(16, 100);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL credit_beat[%0d] got=%h want=%h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_outstanding();
        clear_logs();
        rr_budget = 0;
        push_ar(32'h300, 4'd1, 8'd3);
        push_ar(32'h340, 4'd2, 8'd3);
        push_ar(32'h380, 4'd3, 8'd3);
        cycles(20);
        checks++;
        if (ar_count != 2 || axi_arready_o !== 1'b0) begin
            failures++;
            $display("FAIL outst_limit got=%0d/%b want=2/0", ar_count, axi_arready_o);
        end
        rr_budget = 3;
        cycles(10);
        checks++;
        if (ar_count != 2) begin
            failures++;
            $display("FAIL outst_before_rlast got=%0d want=2", ar_count);
        end
        rr_budget = 1;
        cycles(10);
        checks++;
        if (ar_count != 3) begin
            failures++;
            $display("FAIL outst_after_rlast got=%0d want=3", ar_count);
        end
        rr_budget = -1;
        wait_obs(12, 100);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL outst_beat[%0d] got=%h want=%h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_stalls();
        logic [7:0] len;
        clear_logs();
        stab_err = 0;
        ovf_err = 0;
        rr_pct = 70; acc_pct = 60; mv_pct = 75; rr_budget = -1;
        push_ar(32'hFFFF_FFE0, 4'hA, 8'd15);
        for (int n = 0; n < 100; n++) begin
            case ($urandom_range(2, 0))
                0:       len = 8'd3;
                1:       len = 8'd7;
                default: len = 8'd15;
            endcase
            push_ar({$urandom() >> 4, 4'h0}, 4'($urandom_range(15, 0)), len);
        end
        wait_obs(exp_q.size(), 30000);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL stalls_beat_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stalls_beat[%0d] got=%h want=%h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        cycles(5);
        checks++;
        if (stab_err != 0 || ovf_err != 0) begin
            failures++;
            $display("FAIL stalls_protocol got=%0d/%0d want=0/0", stab_err, ovf_err);
        end
        checks++;
        if (dut.credits_r !== 4'(DFD) || mem_fetch_o !== 1'b0 || axi_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL stalls_idle_credits got=%0d want=%0d", dut.credits_r, DFD);
        end
        rr_pct = 100; acc_pct = 100; mv_pct = 100;
    endtask

    task automatic test_reset_mid();
        clear_logs();
        rr_budget = 2;
        push_ar(32'h500, 4'd6, 8'd3);
        wait_obs(2, 50);
        reset = 1'b1;
        ar_q.delete();
        mem_q.delete();
        clear_logs();
        cycles(1);
        checks++;
        if ({axi_rvalid_o, mem_fetch_o, axi_arready_o} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_outputs got=%b want=000",
                     {axi_rvalid_o, mem_fetch_o, axi_arready_o});
        end
        reset = 1'b0;
        rr_budget = -1;
        cycles(1);
        push_ar(32'h600, 4'd7, 8'd3);
        wait_obs(4, 60);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midreset_beat[%0d] got=%h want=%h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        cycles(3);
        checks++;
        if (dut.credits_r !== 4'(DFD)) begin
            failures++;
            $display("FAIL midreset_credits got=%0d want=%0d", dut.credits_r, DFD);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_long();
        test_credit();
        test_outstanding();
        test_stalls();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_path.md
# axi_rd_path

Read datapath for the AXI4-to-SDRAM interface. This is the counterpart of the write path. It accepts AXI4 read requests and splits each one into 4-beat (BL8) fetch commands for the memory controller. It buffers the returned read-data and presents it on the AXI4 R channel with the correct RID and RLAST. Fetches are credit-limited, so the memory controller never stalls on a full read-data buffer.

## Interface
Parameters:
- ADDRS, 32, byte-address width
- WIDTH, 32, data width; MASKS = WIDTH/8
- AXI_ID_WIDTH, 4, ID width
- CTRL_FIFO_DEPTH, 16, outstanding AXI requests (ID/length FIFO depth), power of 2
- DATA_FIFO_DEPTH, 512, read-data buffer depth in words, power of 2, ≥4

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- axi_arvalid_i / axi_arready_o  in/out  1  AR handshake
- axi_araddr_i  in  ADDRS  start byte address
- axi_arid_i  in  AXI_ID_WIDTH  request ID
- axi_arlen_i  in  8  beats-1
- axi_arburst_i  in  2  burst type; only INCR is supported
- axi_rvalid_o / axi_rready_i  out/in  1  R handshake
- axi_rlast_o  out  1  final beat of the AXI burst
- axi_rresp_o  out  2  always OKAY (00)
- axi_rid_o  out  AXI_ID_WIDTH  ID of the current burst
- axi_rdata_o  out  WIDTH  read data
- mem_fetch_o / mem_accept_i  out/in  1  fetch-command handshake
- mem_rseq_o  out  1  0 for the first chunk of a burst, 1 for subsequent chunks
- mem_rdid_o  out  AXI_ID_WIDTH  ID of the fetch
- mem_addr_o  out  ADDRS  chunk byte address
- mem_valid_i / mem_ready_o  in/out  1  returned-data handshake
- mem_last_i  in  1  last beat of a chunk (checked only, not used for framing)
- mem_data_i  in  WIDTH  returned data

## Operation
Length and address rules:
- Effective length: L = {arlen[7:2], 2'b11}, so the burst is rounded up to a whole number of chunks.
- Chunk count: C = arlen[7:2] + 1.
- Chunk address step: 4*MASKS bytes, with wrap-around modulo 2^ADDRS.

Request FSM, one-hot:
- IDLE: axi_arready_o = 1 when the ID/length FIFO is not full.
  - On an AR handshake: latch addr, id, remaining = C-1 and seq = 0; push {id, L} to the ID/length FIFO; go to ISSUE.
  - arready is 0 outside IDLE.
- ISSUE: mem_fetch_o = 1 when credits ≥ 4.
  - On mem_accept_i: credits -= 4, addr += 4*MASKS, seq = 1, remaining -= 1.
  - If remaining was 0, go to IDLE; arready reasserts on the next cycle.

Credit counter:
- Width $clog2(DATA_FIFO_DEPTH)+1; reset value DATA_FIFO_DEPTH.
- +1 per R handshake, -4 per fetch accept.
- Both events in the same cycle give a net -3.
- The counter never goes negative and never exceeds DATA_FIFO_DEPTH.

Data FIFO:
- Type sync_fifo, WIDTH wide, DATA_FIFO_DEPTH deep.
- mem_ready_o = FIFO ready. Credits guarantee this is 1 whenever data arrives.

Response side:
- axi_rvalid_o = data FIFO valid AND ID/length FIFO valid.
- An 8-bit beat counter increments on each R handshake.
- axi_rlast_o = (beat == L).
- On an RLAST handshake: clear beat and pop the ID/length FIFO.
- axi_rid_o comes from the ID/length FIFO head.

Simulation-only errors (the hardware proceeds in every case):
- arburst ≠ INCR
- arlen[1:0] ≠ 3
- araddr[3:0] ≠ 0
- mem_last_i does not match every 4th beat

## Timing
- Reset values:
  - axi_arready_o 0, asserted 1 cycle after reset deasserts
  - mem_fetch_o 0, axi_rvalid_o 0, axi_rlast_o 0, axi_rresp_o 00
  - FSM in IDLE, credits = DATA_FIFO_DEPTH, both FIFOs empty
- Reset mid-operation drops all outstanding requests and data.
- AR accepted in cycle N gives mem_fetch_o in N+1, provided credits ≥ 4.
- Fetch commands are back-to-back: one chunk per cycle while mem_accept_i is high.
- mem_valid_i beat in cycle M gives axi_rvalid_o in M+1 (first-word fall-through, 1-cycle FIFO latency).
- R data, RID and RLAST are held stable while rvalid is high and rready is low.
- A new AR can be accepted while the R channel is still draining earlier bursts, up to CTRL_FIFO_DEPTH outstanding.
- R-channel ordering is strictly in AR-acceptance order.

## Structure
- Shared package holds BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00, and CHUNK_BEATS = 4. These are the same constants the write path uses.
- Instantiate sync_fifo twice: ID/length FIFO (AXI_ID_WIDTH+8 bits wide, CTRL_FIFO_DEPTH deep) and data FIFO.
- No new sub-module. The chunking is small enough to live in the ISSUE state.

## Test plan
1. **Single burst.** AR addr=0x100, len=3, id=5; memory returns 4 words → one fetch (addr 0x100, rseq=0, rdid=5); 4 R beats with rid=5, rlast on beat 4, rresp=00.
2. **Long burst.** len=15, addr=0x200 → fetches at 0x200, 0x210, 0x220, 0x230 with rseq 0,1,1,1; 16 R beats, rlast only on beat 16.
3. **Credit limit.** DATA_FIFO_DEPTH=8, rready held 0, AR len=15 → exactly 2 fetches issued, then mem_fetch_o stays 0. Each 4 R handshakes after rready=1 releases exactly one further fetch.
4. **Outstanding limit.** CTRL_FIFO_DEPTH=2, three ARs (ids 1,2,3) with rready=0 → third arready stays 0 until id 1 completes its RLAST; R order is 1,2,3.
5. **Stalls.** Random rready and mem_accept_i stalls over 100 random 4/8/16-beat bursts → data matches the scoreboard and the credit counter returns to DATA_FIFO_DEPTH at idle.
6. **Reset mid-burst.** Reset asserted mid-burst (after 2 of 4 beats) → next cycle rvalid=0, fetch=0, arready=0; a fresh burst afterwards completes correctly.
